cpu_3bit: RTL and testbench

//  Single-cycle 3-bit teaching CPU: 8x9-bit unified program/data RAM, four 3-bit registers, one

---
 rtl/cpu_pkg.sv | 44 ++++
 rtl/cpu_alu.sv | 21 ++
 rtl/cpu_3bit.sv | 124 ++++++++++++
 tb/tb_cpu_3bit.sv | 168 ++++++++++++++++
 4 files changed

// File: rtl/cpu_pkg.sv
// Shared widths, instruction-class/op encodings and field extractors for the 3-bit CPU.
package cpu_pkg;
    localparam int DATA_W  = 3;
    localparam int INSTR_W = 9;
    localparam int DEPTH   = 8;

    typedef enum logic [1:0] {
        CLS_IMM = 2'b00,
        CLS_JMP = 2'b01,
        CLS_MEM = 2'b10,
        CLS_REG = 2'b11
    } cls_e;

    localparam logic [1:0] OP_ADD   = 2'b00;
    localparam logic [1:0] OP_CMP   = 2'b01;
    localparam logic [1:0] OP_SHL   = 2'b10;
    localparam logic [1:0] OP_SHR   = 2'b11;
    localparam logic [1:0] OP_JE    = 2'b00;
    localparam logic [1:0] OP_JMP   = 2'b01;
    localparam logic [1:0] OP_JNE   = 2'b10;
    localparam logic [1:0] OP_STORE = 2'b00;
    localparam logic [1:0] OP_LOAD  = 2'b01;

    function automatic cls_e f_cls(input logic [INSTR_W-1:0] instr);
        return cls_e'(instr[8:7]);
    endfunction

    function automatic logic [1:0] f_op(input logic [INSTR_W-1:0] instr);
        return instr[6:5];
    endfunction

    function automatic logic [1:0] f_rd(input logic [INSTR_W-1:0] instr);
        return instr[4:3];
    endfunction

    // Rs for register ALU ops, Ra for memory ops
    function automatic logic [1:0] f_rs(input logic [INSTR_W-1:0] instr);
        return instr[2:1];
    endfunction

    function automatic logic [DATA_W-1:0] f_imm(input logic [INSTR_W-1:0] instr);
        return instr[2:0];
    endfunction
endpackage

// File: rtl/cpu_alu.sv
// Combinational ALU: ADD/CMP/SHL/SHR on 3-bit operands, plus equality for CMP.
module cpu_alu
    import cpu_pkg::*;
(
    input  logic [DATA_W-1:0] i_a,
    input  logic [DATA_W-1:0] i_b,
    input  logic [1:0]        i_op,
    output logic [DATA_W-1:0] o_result,
    output logic              o_eq
);
    always_comb begin
        o_result = i_a;
        o_eq     = (i_a == i_b);
        case (i_op)
            OP_ADD:  o_result = i_a + i_b;
            OP_SHL:  o_result = (i_b >= DATA_W'(DATA_W)) ? '0 : (i_a << i_b);
            OP_SHR:  o_result = (i_b >= DATA_W'(DATA_W)) ? '0 : (i_a >> i_b);
            default: o_result = i_a;
        endcase
    end
endmodule

// File: rtl/cpu_3bit.sv
// Single-cycle 3-bit teaching CPU with unified 8x9 RAM, 4 registers and a Z flag.
// Define CPU_LOAD_EN to enable the LOAD instruction (otherwise that encoding is a NOP).
module cpu_3bit
    import cpu_pkg::*;
(
    input  logic               clk,
    input  logic               reset,
    input  logic               PC_Enable,
    input  logic               RAM_Write_Enable,
    input  logic [DATA_W-1:0]  RAM_Write_Address,
    input  logic [INSTR_W-1:0] RAM_Write_Data,
    input  logic               InE,
    input  logic [DATA_W-1:0]  InD,
    output logic [DATA_W-1:0]  OutD,
    output logic [DATA_W-1:0]  PC,
    output logic [INSTR_W-1:0] PI,
    output logic [DATA_W-1:0]  REG0,
    output logic [DATA_W-1:0]  REG1,
    output logic [DATA_W-1:0]  REG2,
    output logic [DATA_W-1:0]  REG3,
    output logic [INSTR_W-1:0] RAM0,
    output logic [INSTR_W-1:0] RAM1,
    output logic [INSTR_W-1:0] RAM2,
    output logic [INSTR_W-1:0] RAM3,
    output logic [INSTR_W-1:0] RAM4,
    output logic [INSTR_W-1:0] RAM5,
    output logic [INSTR_W-1:0] RAM6,
    output logic [INSTR_W-1:0] RAM7
);
    logic [DATA_W-1:0]  r_pc;
    logic               r_z;
    logic [DATA_W-1:0]  r_regs [4];
    logic [INSTR_W-1:0] r_ram  [DEPTH];

    logic [INSTR_W-1:0] w_instr;
    cls_e               w_cls;
    logic [DATA_W-1:0]  w_rd_val, w_rs_val, w_b, w_alu_res;
    logic               w_alu_eq;
    logic               w_reg_we, w_z_we, w_ram_we, w_jump;
    logic [DATA_W-1:0]  w_reg_wdata, w_pc_next;

    assign w_instr  = r_ram[r_pc];
    assign w_cls    = f_cls(w_instr);
    assign w_rd_val = r_regs[f_rd(w_instr)];
    assign w_rs_val = r_regs[f_rs(w_instr)];
    assign w_b      = (w_cls == CLS_IMM) ? f_imm(w_instr) : w_rs_val;

    cpu_alu u_alu (
        .i_a      (w_rd_val),
        .i_b      (w_b),
        .i_op     (f_op(w_instr)),
        .o_result (w_alu_res),
        .o_eq     (w_alu_eq)
    );

    always_comb begin
        w_reg_we    = 1'b0;
        w_reg_wdata = w_alu_res;
        w_z_we      = 1'b0;
        w_ram_we    = 1'b0;
        w_jump      = 1'b0;
        case (w_cls)
            CLS_IMM, CLS_REG: begin
                if (f_op(w_instr) == OP_CMP) w_z_we   = 1'b1;
                else                         w_reg_we = 1'b1;
            end
            CLS_JMP: begin
                case (f_op(w_instr))
                    OP_JE:   w_jump = r_z;
                    OP_JMP:  w_jump = 1'b1;
                    OP_JNE:  w_jump = !r_z;
                    default: w_jump = 1'b0;
                endcase
            end
            CLS_MEM: begin
                if (f_op(w_instr) == OP_STORE) w_ram_we = 1'b1;
`ifdef CPU_LOAD_EN
                else if (f_op(w_instr) == OP_LOAD) begin
                    w_reg_we    = 1'b1;
                    w_reg_wdata = r_ram[w_rs_val][DATA_W-1:0];
                end
`endif
            end
            default: ;
        endcase
        w_pc_next = w_jump ? f_imm(w_instr) : r_pc + DATA_W'(1);
    end

    // Later assignments take priority: InE beats instruction writes to R2,
    // external RAM writes beat a same-cycle STORE.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_pc <= '0;
            r_z  <= 1'b0;
            for (int i = 0; i < 4; i++)     r_regs[i] <= '0;
            for (int i = 0; i < DEPTH; i++) r_ram[i]  <= '0;
        end else begin
            if (PC_Enable) begin
                r_pc <= w_pc_next;
                if (w_z_we)   r_z <= w_alu_eq;
                if (w_reg_we) r_regs[f_rd(w_instr)] <= w_reg_wdata;
                if (w_ram_we) r_ram[w_rs_val] <= {{(INSTR_W-DATA_W){1'b0}}, w_rd_val};
            end
            if (InE)              r_regs[2] <= InD;
            if (RAM_Write_Enable) r_ram[RAM_Write_Address] <= RAM_Write_Data;
        end
    end

    assign PC   = r_pc;
    assign PI   = w_instr;
    assign OutD = r_regs[3];
    assign REG0 = r_regs[0];
    assign REG1 = r_regs[1];
    assign REG2 = r_regs[2];
    assign REG3 = r_regs[3];
    assign RAM0 = r_ram[0];
    assign RAM1 = r_ram[1];
    assign RAM2 = r_ram[2];
    assign RAM3 = r_ram[3];
    assign RAM4 = r_ram[4];
    assign RAM5 = r_ram[5];
    assign RAM6 = r_ram[6];
    assign RAM7 = r_ram[7];
endmodule

// File: tb/tb_cpu_3bit.sv
// Directed bench for cpu_3bit: hand-assembled programs with hand-computed results.
module tb_cpu_3bit;
    logic       clk = 1'b0;
    logic       reset;
    logic       PC_Enable, RAM_Write_Enable, InE;
    logic [2:0] RAM_Write_Address, InD;
    logic [8:0] RAM_Write_Data;
    logic [2:0] OutD, PC, REG0, REG1, REG2, REG3;
    logic [8:0] PI, RAM0, RAM1, RAM2, RAM3, RAM4, RAM5, RAM6, RAM7;

    int n_chk = 0;
    int n_pass = 0;

    always #5 clk = ~clk;

    cpu_3bit dut (
        .clk(clk), .reset(reset), .PC_Enable(PC_Enable),
        .RAM_Write_Enable(RAM_Write_Enable), .RAM_Write_Address(RAM_Write_Address),
        .RAM_Write_Data(RAM_Write_Data), .InE(InE), .InD(InD), .OutD(OutD),
        .PC(PC), .PI(PI), .REG0(REG0), .REG1(REG1), .REG2(REG2), .REG3(REG3),
        .RAM0(RAM0), .RAM1(RAM1), .RAM2(RAM2), .RAM3(RAM3),
        .RAM4(RAM4), .RAM5(RAM5), .RAM6(RAM6), .RAM7(RAM7)
    );

    task automatic chk(input string tag, input logic [8:0] got, input logic [8:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", tag, got, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wr(input logic [2:0] a, input logic [8:0] d);
        RAM_Write_Enable  = 1'b1;
        RAM_Write_Address = a;
        RAM_Write_Data    = d;
        tick();
        RAM_Write_Enable  = 1'b0;
    endtask

    task automatic do_reset();
        PC_Enable = 1'b0;
        reset = 1'b1;
        #3;
        reset = 1'b0;
        #1;
    endtask

    initial begin
        reset = 1'b1; PC_Enable = 1'b0; RAM_Write_Enable = 1'b0; InE = 1'b0;
        RAM_Write_Address = '0; RAM_Write_Data = '0; InD = '0;
        #12;
        chk("rst_pc", {6'b0, PC}, 9'h000);
        chk("rst_pi", PI, 9'h000);
        reset = 1'b0;
        @(posedge clk); #1;

        // Program from spec scenario, loaded with InE holding R2=4
        InD = 3'd4; InE = 1'b1;
        wr(3'd0, 9'b11_00_00_10_0);
        wr(3'd1, 9'b00_01_00_100);
        wr(3'd2, 9'b01_00_00_100);
        wr(3'd3, 9'b00_10_00_010);
        wr(3'd4, 9'b11_00_11_00_0);
        wr(3'd5, 9'b00_00_01_111);
        wr(3'd6, 9'b10_00_00_01_0);
        InE = 1'b0;
        chk("load_r2", {6'b0, REG2}, 9'd4);
        chk("load_ram4", RAM4, 9'b11_00_11_00_0);
        PC_Enable = 1'b1;
        tick(); chk("p2_r0", {6'b0, REG0}, 9'd4);
        tick(); tick();
        chk("p2_je_pc", {6'b0, PC}, 9'd4);
        chk("p2_shl_skip", {6'b0, REG0}, 9'd4);
        tick(); chk("p2_outd", {6'b0, OutD}, 9'd4);
        tick(); chk("p2_r1", {6'b0, REG1}, 9'd7);
        tick();
        chk("p2_store", RAM7, 9'b000000100);
        chk("p2_pi7", PI, 9'h004);
        tick();
        chk("p2_wrap_r0", {6'b0, REG0}, 9'd0);
        chk("p2_wrap_pc", {6'b0, PC}, 9'd0);
        tick();
        // Async reset mid-run, checked before any clock edge
        #2;
        reset = 1'b1;
        #1;
        chk("ar_pc", {6'b0, PC}, 9'd0);
        chk("ar_r1", {6'b0, REG1}, 9'd0);
        chk("ar_r2", {6'b0, REG2}, 9'd0);
        chk("ar_outd", {6'b0, OutD}, 9'd0);
        chk("ar_ram0", RAM0, 9'd0);
        chk("ar_ram7", RAM7, 9'd0);
        reset = 1'b0;
        PC_Enable = 1'b0;
        @(posedge clk); #1;

        // CMP/JE/JNE with a false comparison
        wr(3'd0, 9'h004);               // ADD R0,4
        wr(3'd1, 9'b00_01_00_011);      // CMP R0,3
        wr(3'd2, 9'b01_00_00_101);      // JE 5
        wr(3'd3, 9'b01_10_00_101);      // JNE 5
        PC_Enable = 1'b1;
        tick(); tick(); tick();
        chk("je_notaken", {6'b0, PC}, 9'd3);
        tick();
        chk("jne_taken", {6'b0, PC}, 9'd5);

        // Halted: state holds, PI follows external writes to RAM[PC]
        PC_Enable = 1'b0;
        tick(); tick(); tick();
        chk("halt_pc", {6'b0, PC}, 9'd5);
        chk("halt_r0", {6'b0, REG0}, 9'd4);
        wr(3'd5, 9'h1AB);
        chk("halt_pi", PI, 9'h1AB);
        chk("halt_pc2", {6'b0, PC}, 9'd5);

        // Arithmetic wrap and shifts
        do_reset();
        wr(3'd0, 9'h006);               // ADD R0,6
        wr(3'd1, 9'h007);               // ADD R0,7
        wr(3'd2, 9'b00_10_00_001);      // SHL R0,1
        wr(3'd3, 9'b00_11_00_001);      // SHR R0,1
        wr(3'd4, 9'h004);               // ADD R0,4
        wr(3'd5, 9'b00_11_00_011);      // SHR R0,3
        PC_Enable = 1'b1;
        tick(); chk("alu_r0_6", {6'b0, REG0}, 9'd6);
        tick(); chk("alu_add_wrap", {6'b0, REG0}, 9'd5);
        tick(); chk("alu_shl", {6'b0, REG0}, 9'd2);
        tick(); chk("alu_shr1", {6'b0, REG0}, 9'd1);
        tick(); chk("alu_r0_5", {6'b0, REG0}, 9'd5);
        tick(); chk("alu_shr3", {6'b0, REG0}, 9'd0);

        // STORE colliding with external write, then LOAD
        do_reset();
        wr(3'd0, 9'b00_00_01_101);      // ADD R1,5
        wr(3'd1, 9'h003);               // ADD R0,3
        wr(3'd2, 9'b10_00_00_01_0);     // STORE RAM[R1] <= R0
        wr(3'd3, 9'b10_01_00_01_0);     // LOAD R0 <= RAM[R1]
        PC_Enable = 1'b1;
        tick(); tick();
        RAM_Write_Enable = 1'b1; RAM_Write_Address = 3'd5; RAM_Write_Data = 9'h1FD;
        tick();
        RAM_Write_Enable = 1'b0;
        chk("st_ext_wins", RAM5, 9'h1FD);
        tick();
`ifdef CPU_LOAD_EN
        chk("load_r0", {6'b0, REG0}, 9'd5);
`else
        chk("load_nop_r0", {6'b0, REG0}, 9'd3);
`endif
        chk("load_pc", {6'b0, PC}, 9'd4);

        // InE overrides an instruction write to R2 in the same cycle
        do_reset();
        wr(3'd0, 9'b00_00_10_011);      // ADD R2,3
        InD = 3'd6; InE = 1'b1; PC_Enable = 1'b1;
        tick();
        InE = 1'b0;
        chk("ine_override", {6'b0, REG2}, 9'd6);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
